aes_sub_shift_serial: RTL and testbench
=======================================

// Module: aes_sub_shift_serial
// PURPOSE
//  Forward (encryption) SubBytes + ShiftRows engine for the 128-bit AES state.
//  Time-multiplexes a single SubBytes S-box instance over the 16 state bytes.
//  That instance's output is registered on negedge clk.
//  Sits in the encryption datapath between AddRoundKey and MixColumns.
//  It is the forward-direction counterpart of the InvSubState / InvShiftRows path.
// PARAMETERS
//  APPLY_SHIFT  1  1: apply ShiftRows when placing results; 0: SubBytes only, bytes stay in place
// PORTS
//  clk        in   1    system clock; datapath on posedge, S-box register on negedge
//  reset_n    in   1    asynchronous, active-low reset
//  in_valid   in   1    in_state is valid
//  in_ready   out  1    engine can accept a state (high only in IDLE)
//  in_state   in   128  AES state; byte k = in_state[127-8k -: 8]; byte k = row k%4, col k/4
//  out_valid  out  1    out_state holds a finished result
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  result, same byte ordering as in_state
//  busy       out  1    high in RUN
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - FSM goes to IDLE; cnt=0; out_valid=0; out_state=0; busy=0.
//   - in_ready=1 as soon as reset_n deasserts.
//   - The S-box negedge register is not reset; its contents are don't-care.
//  FSM states: IDLE, RUN, DONE. in_ready=(IDLE). busy=(RUN). out_valid=(DONE), registered.
//  IDLE:
//   - in_valid&in_ready at posedge T0: latch in_state into src_q, cnt<=0, go to RUN.
//   - in_valid low: stay in IDLE; out_state holds its last value.
//  RUN:
//   - S-box address = src_q byte[cnt], combinational mux from registered cnt.
//   - The S-box registers S(byte[cnt]) on the negedge inside the cycle.
//   - At each posedge: write the S-box output into out_state byte dst(cnt), then cnt<=cnt+1.
//   - cnt is 4 bits. When cnt==15 is written (posedge T16): go to DONE, out_valid<=1.
//  Placement rule:
//   - cnt=r+4c. dst = r+4*((c-r) mod 4) if APPLY_SHIFT, else cnt.
//   - Column arithmetic is 2-bit wrap-around.
//  Latency: out_valid rises at posedge T16, 16 cycles after the accepting edge.
//  DONE:
//   - out_state is held stable and out_valid held high until out_ready=1.
//   - On out_ready=1: out_valid<=0, go to IDLE.
//   - Next accept is at the earliest 2 cycles after the result handshake.
//   - Minimum period: 18 cycles/state with out_ready tied high.
//  Simultaneous events:
//   - in_valid during RUN/DONE is ignored; the source must hold it until in_ready=1.
//   - out_ready outside DONE has no effect.
//  Reset mid-operation: the in-flight state is discarded; behaviour is as for reset above.
//  out_state is partially updated during RUN. Consumers may only sample it when out_valid=1.
// TESTING
//  1. FIPS-197 App.B round 1, APPLY_SHIFT=1, out_ready tied high:
//     in 193de3bea0f4e22b9ac68d2ae9f84808 -> out d4bf5d30e0b452aeb84111f11e2798e5.
//     out_valid must rise exactly 16 cycles after accept.
//  2. Same input, APPLY_SHIFT=0 -> out d42711aee0bf98f1b8b45de51e415230.
//  3. Input all-zero -> out 6363...63 (all 16 bytes 63).
//     Input 000102...0f, APPLY_SHIFT=0 -> 637c777bf26b6fc53001672bfed7ab76.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     out_valid and out_state must stay stable, in_ready=0.
//     After the handshake, in_ready=1 on the next cycle.
//  5. Assert reset_n=0 at cnt=7 of RUN:
//     out_valid=0, out_state=0, in_ready=1 immediately (async).
//     A new vector accepted afterwards gives the correct result of test 1.
//  6. Back-to-back: in_valid held high with 3 vectors, out_ready high.
//     All 3 results are correct and in order, with an 18-cycle spacing.
//     in_valid during RUN is not accepted.

Source files
------------

// File: rtl/aes_sub_shift_serial.sv
// Forward AES SubBytes + ShiftRows over a 128-bit state, one byte per cycle
// through a single S-box whose output is captured on the falling clock edge.
module aes_sub_shift_serial #(
  parameter int unsigned APPLY_SHIFT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry x sits at bits [8*(255-x) +: 8], so the lsb offset is {~x, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] src_q;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_q;
  logic [1:0]   dst_col;
  logic [3:0]   dst;

  // Byte k lives at lsb 8*(15-k) == {~k, 3'b000} for a 4-bit k.
  always_comb begin
    sbox_in = src_q[{~cnt, 3'b000} +: 8];
    dst_col = cnt[3:2] - cnt[1:0];
    dst     = (APPLY_SHIFT != 0) ? {dst_col, cnt[1:0]} : cnt;
  end

  always_ff @(negedge clk) begin
    sbox_q <= SBOX[{~sbox_in, 3'b000} +: 8];
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      src_q     <= '0;
      out_valid <= 1'b0;
      out_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src_q <= in_state;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          out_state[{~dst, 3'b000} +: 8] <= sbox_q;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift_serial.sv
// Directed bench for aes_sub_shift_serial: one instance with ShiftRows, one
// without, driven by the same stimulus.
module tb_aes_sub_shift_serial;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;
  logic         in_ready_s, out_valid_s, busy_s;
  logic [127:0] out_state_s;
  logic         in_ready_n, out_valid_n, busy_n;
  logic [127:0] out_state_n;

  int n_cmp;
  int n_fail;

  localparam logic [127:0] V_FIPS  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E_FIPS1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] E_FIPS0 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V_ZERO  = 128'h0;
  localparam logic [127:0] E_ZERO  = {16{8'h63}};
  localparam logic [127:0] V_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E_SEQ0  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] E_SEQ1  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;

  aes_sub_shift_serial #(.APPLY_SHIFT(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_state(in_state), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_state(out_state_s), .busy(busy_s)
  );

  aes_sub_shift_serial #(.APPLY_SHIFT(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_state(in_state), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_state(out_state_n), .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts v at the next edge and returns 1 time unit after out_valid rises.
  task automatic send_vec(input logic [127:0] v, input logic [127:0] e_s,
                          input logic [127:0] e_n, input string nm);
    int cyc;
    in_state = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({busy_s, in_ready_s, busy_n, in_ready_n} !== 4'b1010) begin
      n_fail++;
      $display("FAIL %s_run_flags got %b want 1010", nm, {busy_s, in_ready_s, busy_n, in_ready_n});
    end
    cyc = 1;
    while (!out_valid_s && cyc < 40) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc !== 16) begin
      n_fail++;
      $display("FAIL %s_latency got %0d want 16", nm, cyc);
    end
    n_cmp++;
    if (out_state_s !== e_s) begin
      n_fail++;
      $display("FAIL %s_shift got %h want %h", nm, out_state_s, e_s);
    end
    n_cmp++;
    if (out_valid_n !== 1'b1 || out_state_n !== e_n) begin
      n_fail++;
      $display("FAIL %s_noshift got v=%b %h want v=1 %h", nm, out_valid_n, out_state_n, e_n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready_s, out_valid_s, busy_s, in_ready_n, out_valid_n, busy_n} !== 6'b100100
        || out_state_s !== '0 || out_state_n !== '0) begin
      n_fail++;
      $display("FAIL reset_state got rdy/v/busy=%b%b%b out=%h want 100 out=0",
               in_ready_s, out_valid_s, busy_s, out_state_s);
    end
  endtask

  task automatic test_fips();
    send_vec(V_FIPS, E_FIPS1, E_FIPS0, "fips");
    tick();
    n_cmp++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_handshake got v=%b rdy=%b want v=0 rdy=1", out_valid_s, in_ready_s);
    end
  endtask

  task automatic test_patterns();
    send_vec(V_ZERO, E_ZERO, E_ZERO, "zero");
    tick();
    send_vec(V_SEQ, E_SEQ1, E_SEQ0, "seq");
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_vec(V_SEQ, E_SEQ1, E_SEQ0, "bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || out_state_s !== E_SEQ1) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b out=%h want v=1 rdy=0 out=%h",
                 i, out_valid_s, in_ready_s, out_state_s, E_SEQ1);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid_s, in_ready_s);
    end
  endtask

  task automatic test_midrun_reset();
    in_state = V_SEQ;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid_s !== 1'b0 || out_state_s !== '0 || in_ready_s !== 1'b1 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset got v=%b rdy=%b busy=%b out=%h want v=0 rdy=1 busy=0 out=0",
               out_valid_s, in_ready_s, busy_s, out_state_s);
    end
    tick();
    reset_n = 1'b1;
    tick();
    send_vec(V_FIPS, E_FIPS1, E_FIPS0, "after_reset");
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] vecs [3];
    logic [127:0] exps [3];
    logic [127:0] expn [3];
    int acc_cyc [3];
    int res_cyc [3];
    int acc, res, cyc, viol;
    logic rdy, prev_v;
    vecs = '{V_FIPS, V_ZERO, V_SEQ};
    exps = '{E_FIPS1, E_ZERO, E_SEQ1};
    expn = '{E_FIPS0, E_ZERO, E_SEQ0};
    acc = 0; res = 0; cyc = 0; viol = 0; prev_v = 1'b0;
    in_state = vecs[0];
    in_valid = 1'b1;
    while (res < 3 && cyc < 120) begin
      rdy = in_ready_s;
      tick();
      cyc++;
      if (rdy && in_valid) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc < 3) in_state = vecs[acc];
        else in_valid = 1'b0;
      end
      if (out_valid_s && !prev_v) begin
        n_cmp++;
        if (out_state_s !== exps[res] || out_state_n !== expn[res]) begin
          n_fail++;
          $display("FAIL b2b_result%0d got %h/%h want %h/%h",
                   res, out_state_s, out_state_n, exps[res], expn[res]);
        end
        res_cyc[res] = cyc;
        res++;
      end
      prev_v = out_valid_s;
      if (in_ready_s && busy_s) viol++;
    end
    n_cmp++;
    if (acc !== 3 || res !== 3) begin
      n_fail++;
      $display("FAIL b2b_count got acc=%0d res=%0d want 3/3", acc, res);
    end else begin
      n_cmp++;
      if (res_cyc[0] - acc_cyc[0] !== 16 || acc_cyc[1] - acc_cyc[0] !== 18
          || acc_cyc[2] - acc_cyc[1] !== 18 || res_cyc[1] - res_cyc[0] !== 18
          || res_cyc[2] - res_cyc[1] !== 18) begin
        n_fail++;
        $display("FAIL b2b_spacing got acc=%0d,%0d,%0d res=%0d,%0d,%0d want step 18 latency 16",
                 acc_cyc[0], acc_cyc[1], acc_cyc[2], res_cyc[0], res_cyc[1], res_cyc[2]);
      end
    end
    n_cmp++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL b2b_ready_in_run got %0d cycles want 0", viol);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_fips();
    test_patterns();
    test_backpressure();
    test_midrun_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
